// File: rtl/pi_pkg.sv
// Shared types and constants for the Monte Carlo pi sampling sequencer.
package pi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } pi_state_e;

   localparam int unsigned PI_COORD_LIMIT = 100;
   localparam int unsigned PI_RADIUS_SQ   = 10000;

   // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15, 13, 12, 10)
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/pi_sample_ctrl_if.sv
// Point/result link between the sample sequencer and the in-circle comparator.
interface pi_sample_ctrl_if #(
   parameter int unsigned COORD_W = 10
);

   logic [COORD_W-1:0] comp_x;
   logic [COORD_W-1:0] comp_y;
   logic               in_circle;

   modport master (
      output comp_x,
      output comp_y,
      input  in_circle
   );

   modport slave (
      input  comp_x,
      input  comp_y,
      output in_circle
   );

endinterface

// File: rtl/pi_lfsr.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0; loadable.
module pi_lfsr
   import pi_pkg::*;
#(
   parameter logic [15:0] SEED_DEFAULT = pi_pkg::SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        en,
   output logic [15:0] value
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value <= SEED_DEFAULT;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         value <= {value[14:0], ^(value & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/pi_sample_ctrl.sv
// Sequencer for the Monte Carlo pi estimator: issues random points, tallies hits.
// Optional PI_CTRL_REJECT_CNT_EN adds a saturating count of rejected candidates.
module pi_sample_ctrl
   import pi_pkg::*;
#(
   parameter int unsigned SAMPLE_W     = 16,
   parameter int unsigned COORD_W      = 10,
   parameter logic [15:0] SEED_DEFAULT = pi_pkg::SEED_DEFAULT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [SAMPLE_W-1:0] num_samples,
   input  logic [15:0]         seed,
   pi_sample_ctrl_if.master    comp,
   output logic                busy,
   output logic                done,
   output logic [SAMPLE_W-1:0] hit_count,
   output logic [SAMPLE_W-1:0] total_count
`ifdef PI_CTRL_REJECT_CNT_EN
   ,
   output logic [SAMPLE_W+1:0] reject_count
`endif
);

   pi_state_e           state;
   logic [15:0]         lfsr;
   logic [15:0]         load_val;
   logic [1:0]          lfsr_unused;
   logic [6:0]          cand_x;
   logic [6:0]          cand_y;
   logic                accept;
   logic                start_go;
   logic                lfsr_en;
   logic                issue_q;
   logic [SAMPLE_W-1:0] num_q;

   always_comb begin
      cand_x      = lfsr[6:0];
      cand_y      = lfsr[13:7];
      lfsr_unused = lfsr[15:14];
      accept      = (cand_x < 7'(PI_COORD_LIMIT)) && (cand_y < 7'(PI_COORD_LIMIT));
      start_go    = (state == IDLE) && start && !abort;
      lfsr_en     = (state == RUN);
      load_val    = (seed == '0) ? SEED_DEFAULT : seed;
   end

   pi_lfsr #(
      .SEED_DEFAULT (SEED_DEFAULT)
   ) u_lfsr (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (start_go),
      .load_val (load_val),
      .en       (lfsr_en),
      .value    (lfsr)
   );

   // in_circle answers the point presented while issue_q is high; an abort
   // on that edge discards it so the counts stay at their partial values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         hit_count   <= '0;
         total_count <= '0;
         comp.comp_x <= '0;
         comp.comp_y <= '0;
         issue_q     <= 1'b0;
         num_q       <= '0;
      end else begin
         done    <= 1'b0;
         issue_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start_go) begin
                  num_q       <= num_samples;
                  hit_count   <= '0;
                  total_count <= '0;
                  if (num_samples != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (issue_q && comp.in_circle) begin
                     hit_count <= hit_count + 1'b1;
                  end
                  if (accept) begin
                     comp.comp_x <= COORD_W'(cand_x);
                     comp.comp_y <= COORD_W'(cand_y);
                     issue_q     <= 1'b1;
                     total_count <= total_count + 1'b1;
                     if (total_count == num_q - 1'b1) begin
                        state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               busy <= 1'b0;
               if (abort) begin
                  state <= IDLE;
               end else begin
                  if (issue_q && comp.in_circle) begin
                     hit_count <= hit_count + 1'b1;
                  end
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PI_CTRL_REJECT_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reject_count <= '0;
      end else if (start_go) begin
         reject_count <= '0;
      end else if ((state == RUN) && !abort && !accept && (reject_count != '1)) begin
         reject_count <= reject_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pi_sample_ctrl.sv
// Self-checking bench for pi_sample_ctrl against a list-based reference of each run.
module tb_pi_sample_ctrl;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned COORD_W  = 10;

   logic                clk;
   logic                reset_n;
   logic                start;
   logic                abort;
   logic [SAMPLE_W-1:0] num_samples;
   logic [15:0]         seed;
   logic                busy;
   logic                done;
   logic [SAMPLE_W-1:0] hit_count;
   logic [SAMPLE_W-1:0] total_count;
`ifdef PI_CTRL_REJECT_CNT_EN
   logic [SAMPLE_W+1:0] reject_count;
`endif

   int checks = 0;
   int errors = 0;

   // Reference run: cycle index (1 = first RUN cycle) and coordinates of each accepted point
   int m_t[$];
   int m_x[$];
   int m_y[$];
   int m_hit[$];

   pi_sample_ctrl_if #(.COORD_W(COORD_W)) cif ();

   // Comparator answers for the point currently held on comp_x/comp_y
   assign cif.in_circle = ((int'(cif.comp_x) * int'(cif.comp_x)
                          + int'(cif.comp_y) * int'(cif.comp_y)) < 10000);

   pi_sample_ctrl #(
      .SAMPLE_W (SAMPLE_W),
      .COORD_W  (COORD_W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .num_samples  (num_samples),
      .seed         (seed),
      .comp         (cif),
      .busy         (busy),
      .done         (done),
      .hit_count    (hit_count),
      .total_count  (total_count)
`ifdef PI_CTRL_REJECT_CNT_EN
      ,
      .reject_count (reject_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      int v;
      int fb;
      v  = int'(s);
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return 16'(((v * 2) % 65536) + fb);
   endfunction

   task automatic build_model(input logic [15:0] sd, input int n);
      logic [15:0] s;
      int t;
      int x;
      int y;
      m_t.delete();
      m_x.delete();
      m_y.delete();
      m_hit.delete();
      s = (sd == 16'h0) ? 16'hACE1 : sd;
      t = 1;
      while (m_t.size() < n) begin
         x = int'(s) % 128;
         y = (int'(s) / 128) % 128;
         if (x < 100 && y < 100) begin
            m_t.push_back(t);
            m_x.push_back(x);
            m_y.push_back(y);
            m_hit.push_back((x * x + y * y < 10000) ? 1 : 0);
         end
         s = lfsr_next(s);
         t++;
      end
   endtask

   task automatic run(input logic [15:0] sd, input int n, input bit per_cycle,
                      input int mid_start, input string tag);
      int c;
      int k;
      int exp_done;
      int hits;
      build_model(sd, n);
      hits = 0;
      foreach (m_hit[i]) hits += m_hit[i];
      exp_done = (n == 0) ? 1 : m_t[m_t.size() - 1] + 2;
      seed        = sd;
      num_samples = SAMPLE_W'(n);
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 1;
      k = 0;
      forever begin
         if (per_cycle) begin
            while (k < m_t.size() && m_t[k] < c) k++;
            check({tag, "_total"}, total_count, k);
            check({tag, "_busy"}, busy, (c < exp_done) ? 1 : 0);
            check({tag, "_done_pulse"}, done, (c == exp_done) ? 1 : 0);
            if (k > 0) begin
               check({tag, "_x"}, cif.comp_x, m_x[k - 1]);
               check({tag, "_y"}, cif.comp_y, m_y[k - 1]);
            end
         end
         if (done === 1'b1 || c >= exp_done + 4) break;
         if (c == mid_start) begin
            start       = 1'b1;
            seed        = 16'h5555;
            num_samples = 3;
         end else if (c == mid_start + 1) begin
            start       = 1'b0;
            seed        = sd;
            num_samples = SAMPLE_W'(n);
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_done_cycle"}, c, exp_done);
      check({tag, "_final_total"}, total_count, n);
      check({tag, "_final_hits"}, hit_count, hits);
      check({tag, "_busy_at_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_hits_hold"}, hit_count, hits);
   endtask

   initial begin
      logic [15:0] sd;
      int n;
      int exp_total;
      int exp_hits;
      reset_n     = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      num_samples = '0;
      seed        = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hits", hit_count, 0);
      check("rst_total", total_count, 0);
      check("rst_x", cif.comp_x, 0);
      check("rst_y", cif.comp_y, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Known single points
      run(16'h0001, 1, 1'b1, 0, "seed0001");
      check("seed0001_hit", hit_count, 1);
      run(16'h31E3, 1, 1'b1, 0, "seed31E3");
      check("seed31E3_miss", hit_count, 0);
      check("seed31E3_x99", cif.comp_x, 99);
      run(16'h007F, 4, 1'b1, 0, "seed007F");

      // Zero-length run, then default seed
      run(16'h0000, 0, 1'b1, 0, "zero_n");
      run(16'h0000, 1, 1'b1, 0, "default_seed");
      check("default_seed_x", cif.comp_x, 97);
      check("default_seed_y", cif.comp_y, 89);
      check("default_seed_miss", hit_count, 0);

      for (int i = 0; i < 6; i++) begin
         sd = 16'($urandom);
         n  = int'($urandom_range(1, 40));
         run(sd, n, 1'b1, 0, "rand");
      end

      // Long run with a stray start pulse that must be ignored
      run(16'h1234, 10000, 1'b0, 500, "big");

      // abort together with start in IDLE: no run begins
      start       = 1'b1;
      abort       = 1'b1;
      num_samples = 5;
      seed        = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("abort_idle_busy", busy, 0);
      check("abort_idle_done", done, 0);
      @(posedge clk); #1;
      check("abort_idle_busy2", busy, 0);

      // abort during T5 of a 100-sample run
      sd = 16'($urandom);
      build_model(sd, 100);
      exp_total = 0;
      exp_hits  = 0;
      foreach (m_t[i]) begin
         if (m_t[i] <= 4) exp_total++;
         if (m_t[i] <= 3) exp_hits += m_hit[i];
      end
      seed        = sd;
      num_samples = 100;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_total", total_count, exp_total);
      check("abort_hits", hit_count, exp_hits);
      for (int i = 0; i < 8; i++) begin
         check("abort_no_done", done, 0);
         @(posedge clk); #1;
      end
      check("abort_total_frozen", total_count, exp_total);
      check("abort_hits_frozen", hit_count, exp_hits);

      // Reset mid-run clears outputs without waiting for an edge
      seed        = 16'($urandom);
      num_samples = 50;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hits", hit_count, 0);
      check("midrst_total", total_count, 0);
      check("midrst_x", cif.comp_x, 0);
      check("midrst_y", cif.comp_y, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
      run(16'h0001, 1, 1'b1, 0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pi_sample_ctrl.md
# pi_sample_ctrl

Sequencer for the Monte Carlo π estimator. On `start` it generates pseudo-random (x, y) points in the quarter-square 0..99 × 0..99 and drives them into the external one-cycle registered in-circle comparator (x²+y² < 10000). It collects the comparator's `in_circle` result one cycle later and reports hit and sample counts when the requested number of samples is complete. It sits between the host/control register block and the comparator instance.

## Interface
Parameters:
- `SAMPLE_W`, 16: width of `num_samples`, `hit_count` and `total_count`.
- `COORD_W`, 10: width of the comparator coordinate ports.
- `SEED_DEFAULT`, 16'hACE1: LFSR value substituted when `seed` is 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel the run in progress; returns to IDLE with no `done`.
- `num_samples`  in  SAMPLE_W  accepted points per run; captured on `start`.
- `seed`  in  16  LFSR seed; captured on `start`.
- `comp_x`  out  COORD_W  x to comparator, zero-extended 7-bit value.
- `comp_y`  out  COORD_W  y to comparator, zero-extended 7-bit value.
- `in_circle`  in  1  comparator result, valid the cycle after issue.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at run completion.
- `hit_count`  out  SAMPLE_W  points with `in_circle`=1; holds until next `start`.
- `total_count`  out  SAMPLE_W  points issued; holds until next `start`.

## Operation
- The LFSR is 16-bit Fibonacci, taps x¹⁶+x¹⁴+x¹³+x¹¹+1.
  - It shifts left with feedback into bit 0 every RUN cycle.
  - The candidate point is x = lfsr[6:0], y = lfsr[13:7] of the current state.
- Rejection rule: a candidate with x ≥ 100 or y ≥ 100 is discarded. No issue occurs that cycle, but the LFSR still steps.
- States:
  - IDLE → RUN on `start` with `num_samples` ≠ 0. This loads the LFSR (`seed`, or `SEED_DEFAULT` if `seed` is 0) and clears both counts.
  - IDLE → DONE on `start` with `num_samples` = 0. Counts are cleared.
  - RUN: each accepted candidate is driven on `comp_x`/`comp_y`, an internal issue flag is set, and `total_count` increments. After the issue that makes `total_count` equal `num_samples`, RUN → DRAIN.
  - DRAIN: one cycle that collects the last comparator result. DRAIN → DONE.
  - DONE: `done`=1 for one cycle. DONE → IDLE.
- Accumulation: `hit_count` += `in_circle` in every cycle whose previous cycle issued a point.
- `comp_x`/`comp_y` hold their last issued value when no issue occurs.
- `start` in any state other than IDLE is ignored.
- `abort` in RUN or DRAIN forces IDLE on the next edge.
  - No `done` is produced.
  - Counts freeze at their partial values; a result still pending in the comparator is dropped.
- `abort` and `start` in the same IDLE cycle: `abort` wins and no run starts.
- `abort` has no effect in IDLE or DONE.
- Counts never wrap, because `total_count` ≤ `num_samples` ≤ 2^SAMPLE_W − 1.

## Timing
- Reset values (asynchronous):
  - state IDLE, `busy`=0, `done`=0;
  - `hit_count`=0, `total_count`=0;
  - `comp_x`=0, `comp_y`=0;
  - LFSR = `SEED_DEFAULT`;
  - issue flag = 0.
- `reset_n` asserted mid-run clears everything immediately; no `done` is produced.
- Comparator latency is exactly 1 cycle. `in_circle` is only consumed in the cycle after an issue.
- Cycle numbering, with `start` sampled at edge T0:
  - RUN occupies T1..Tk, where Tk is the last issue;
  - DRAIN is Tk+1;
  - `done`=1 during Tk+2 (DONE), with `busy`=0.
- With `num_samples`=0: `done`=1 during T1.
- Throughput is one accepted point per cycle, so the expected run length is ≈ N/0.61 + 2 cycles.
- `hit_count`/`total_count` are final and stable from the cycle `done` is high.

## Configuration
- `PI_CTRL_REJECT_CNT_EN` defined:
  - adds output `reject_count` (SAMPLE_W+2 bits), which counts discarded candidates;
  - it is cleared on `start` and saturates at all-ones;
  - its reset value is 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `pi_pkg` holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - `PI_COORD_LIMIT`=100;
  - `PI_RADIUS_SQ`=10000;
  - the LFSR tap mask;
  - `SEED_DEFAULT`.
- Sub-module `pi_lfsr` contains the 16-bit LFSR, with load, enable and current-state output. The FSM, counters and issue pipeline stay in `pi_sample_ctrl`.
- The comparator is instantiated beside this block at the top level, not inside it.

## Test plan
- `seed`=16'h0001, `num_samples`=1: first point (1,0) is issued at T1 → `hit_count`=1, `total_count`=1, `done` at T3.
- `seed`=16'h31E3, `num_samples`=1: point (99,99) gives 19602 ≥ 10000 → `hit_count`=0, `total_count`=1.
- `seed`=16'h007F: x=127 is rejected at T1 → no issue at T1, `total_count` stays 0 until the next accepted candidate.
- `num_samples`=0, `seed`=0:
  - `done` at T1, both counts 0;
  - a following run with `num_samples`=1 issues the candidate from LFSR 16'hACE1 (x=97, y=89, a miss).
- `num_samples`=10000, `seed`=16'h1234 → counts match a golden LFSR model exactly; `start` pulsed mid-run is ignored.
- `abort` at T5 of a 100-sample run → IDLE at T6, no `done`, counts frozen; `reset_n` low mid-run → all outputs 0 immediately.
